// File: rtl/pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage
//
// One pipeline stage with a skid buffer. The main register drives the outputs
// and a single skid register catches the entry offered in the same cycle that
// downstream stalls. Because the skid absorbs that entry, in_ready is a plain
// flop output with no combinational path from out_ready, which breaks the
// ready chain between pipeline stages.
//
// States:
//   EMPTY - nothing held
//   BUSY  - main register valid
//   FULL  - main and skid registers valid (upstream is stalled)
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset, highest priority
//   flush      in   synchronous kill of every held entry
//   in_valid   in   upstream offers an entry
//   in_ready   out  stage can accept (registered)
//   in_ctrl    in   control payload of the offered entry  [CTRL_W]
//   in_data    in   datapath payload of the offered entry [DATA_W]
//   out_valid  out  stage presents an entry (registered)
//   out_ready  in   downstream accepts
//   out_ctrl   out  control payload, zero whenever out_valid is 0 [CTRL_W]
//   out_data   out  datapath payload, holds last value when idle [DATA_W]
//   stall_cnt  out  saturating count of out_valid && !out_ready cycles [CNT_W]
// -----------------------------------------------------------------------------
module pipe_skid_stage #(
    parameter int DATA_W = 160,
    parameter int CTRL_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;

    // Handshake flags are kept as their own flops so the ports are driven
    // directly by a register rather than by a state decode.
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [CTRL_W-1:0]  main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]  main_data_q, main_data_d;
    logic [CTRL_W-1:0]  skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0]  skid_data_q, skid_data_d;

    logic [CNT_W-1:0]   stall_q, stall_d;

    logic               in_xfer;
    logic               out_xfer;

    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = out_valid_q && out_ready;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values of the others, independent of the
    // order in which the simulator evaluates processes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every variable written in a combinational block gets a default
    // assignment first; a path that leaves it unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            // Any entry accepted this cycle is discarded along with the rest.
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_xfer) state_d = BUSY;
                end
                BUSY: begin
                    if (in_xfer && !out_xfer)      state_d = FULL;
                    else if (!in_xfer && out_xfer) state_d = EMPTY;
                end
                FULL: begin
                    // in_ready is low here, so only the output side can move.
                    if (out_xfer) state_d = BUSY;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM: output logic (computed from the next state, then registered)
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    // -------------------------------------------------------------------------
    // Payload steering
    // -------------------------------------------------------------------------
    always_comb begin
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        // A flush leaves the datapath payload untouched so out_data keeps its
        // last presented value; only control is cleared below.
        if (!flush) begin
            unique case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                BUSY: begin
                    if (in_xfer && out_xfer) begin
                        // Pass-through: one entry per cycle.
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (in_xfer) begin
                        // Downstream stalled while upstream still believed
                        // in_ready: park the entry in the skid.
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                    end
                end
                default: ;
            endcase
        end

        // Bubbles carry no control: clearing here keeps out_ctrl a pure flop.
        if (state_d == EMPTY) begin
            main_ctrl_d = '0;
        end
    end

    // NOTE: the payload registers are reset because their reset value is
    // visible on out_data; storage whose contents never reach an output
    // before being written would not need a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

    // -------------------------------------------------------------------------
    // Saturating stall counter (flush does not touch it)
    // -------------------------------------------------------------------------
    always_comb begin
        stall_d = stall_q;
        if (out_valid_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_stage
//
// Directed checks of reset, streaming, backpressure, flush, mid-operation
// reset and counter saturation (CNT_W = 4), followed by a randomised
// valid/ready/flush run compared against a queue model of the stage.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_pipe_skid_stage;

    localparam int DW = 32;
    localparam int CW = 12;
    localparam int NW = 4;
    localparam int STALL_MAX = (1 << NW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [NW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          sb[$];
    logic [DW-1:0] last_d;
    int            m_stall;

    pipe_skid_stage #(
        .DATA_W (DW),
        .CTRL_W (CW),
        .CNT_W  (NW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [CW-1:0] c,
                              input logic [DW-1:0] d, input logic rdy, input int st);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(v));
        check({tag, ".out_ctrl"},  64'(out_ctrl),  64'(c));
        check({tag, ".out_data"},  64'(out_data),  64'(d));
        check({tag, ".in_ready"},  64'(in_ready),  64'(rdy));
        check({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(st));
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                         input logic ordy, input logic fl);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    initial begin
        // ---------------- reset ----------------
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        next();
        next();
        expect_out("reset", 1'b0, 12'h000, 32'h0, 1'b1, 0);
        rst = 1'b0;

        // ---------------- streaming 1,2,3,4 ----------------
        drive(1'b1, 12'h011, 32'd1, 1'b1, 1'b0);
        next();
        expect_out("stream1", 1'b1, 12'h011, 32'd1, 1'b1, 0);
        drive(1'b1, 12'h012, 32'd2, 1'b1, 1'b0);
        next();
        expect_out("stream2", 1'b1, 12'h012, 32'd2, 1'b1, 0);
        drive(1'b1, 12'h013, 32'd3, 1'b1, 1'b0);
        next();
        expect_out("stream3", 1'b1, 12'h013, 32'd3, 1'b1, 0);
        drive(1'b1, 12'h014, 32'd4, 1'b1, 1'b0);
        next();
        expect_out("stream4", 1'b1, 12'h014, 32'd4, 1'b1, 0);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        next();
        expect_out("drain", 1'b0, 12'h000, 32'd4, 1'b1, 0);

        // ---------------- backpressure ----------------
        drive(1'b1, 12'h00A, 32'hA, 1'b1, 1'b0);
        next();
        expect_out("bp_a", 1'b1, 12'h00A, 32'hA, 1'b1, 0);
        drive(1'b1, 12'h00B, 32'hB, 1'b0, 1'b0);
        next();
        expect_out("bp_full", 1'b1, 12'h00A, 32'hA, 1'b0, 1);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        next();
        expect_out("bp_hold", 1'b1, 12'h00A, 32'hA, 1'b0, 2);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        next();
        expect_out("bp_b", 1'b1, 12'h00B, 32'hB, 1'b1, 2);
        next();
        expect_out("bp_empty", 1'b0, 12'h000, 32'hB, 1'b1, 2);

        // ---------------- flush while FULL ----------------
        drive(1'b1, 12'h00D, 32'hD, 1'b1, 1'b0);
        next();
        expect_out("fl_d", 1'b1, 12'h00D, 32'hD, 1'b1, 2);
        drive(1'b1, 12'h00E, 32'hE, 1'b0, 1'b0);
        next();
        expect_out("fl_full", 1'b1, 12'h00D, 32'hD, 1'b0, 3);
        drive(1'b1, 12'hFFF, 32'hC, 1'b0, 1'b1);
        next();
        expect_out("fl_kill", 1'b0, 12'h000, 32'hD, 1'b1, 4);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        next();
        expect_out("fl_after", 1'b0, 12'h000, 32'hD, 1'b1, 4);
        // Entry accepted in the flush cycle while EMPTY is discarded.
        drive(1'b1, 12'h077, 32'h77, 1'b1, 1'b1);
        next();
        expect_out("fl_empty_in", 1'b0, 12'h000, 32'hD, 1'b1, 4);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        next();
        expect_out("fl_gone", 1'b0, 12'h000, 32'hD, 1'b1, 4);

        // ---------------- reset mid-operation ----------------
        drive(1'b1, 12'h00F, 32'hF, 1'b1, 1'b0);
        next();
        expect_out("rm_f", 1'b1, 12'h00F, 32'hF, 1'b1, 4);
        drive(1'b1, 12'h010, 32'h10, 1'b0, 1'b0);
        next();
        expect_out("rm_full", 1'b1, 12'h00F, 32'hF, 1'b0, 5);
        rst = 1'b1;
        next();
        expect_out("rm_reset", 1'b0, 12'h000, 32'h0, 1'b1, 0);
        rst = 1'b0;
        drive(1'b1, 12'h055, 32'h55, 1'b0, 1'b0);
        next();
        expect_out("rm_first", 1'b1, 12'h055, 32'h55, 1'b1, 0);

        // ---------------- stall counter saturation ----------------
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (14) next();
        expect_out("sat14", 1'b1, 12'h055, 32'h55, 1'b1, 14);
        repeat (6) next();
        expect_out("sat20", 1'b1, 12'h055, 32'h55, 1'b1, STALL_MAX);

        // ---------------- random run against queue model ----------------
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        next();
        rst = 1'b0;
        sb.delete();
        last_d  = '0;
        m_stall = 0;
        for (int i = 0; i < 10000; i++) begin
            logic mv;
            logic mr;
            mv = (sb.size() > 0);
            mr = (sb.size() < 2);
            check("rnd.out_valid", 64'(out_valid), 64'(mv));
            check("rnd.in_ready",  64'(in_ready),  64'(mr));
            check("rnd.out_ctrl",  64'(out_ctrl),  mv ? 64'(sb[0].c) : 64'd0);
            check("rnd.out_data",  64'(out_data),  mv ? 64'(sb[0].d) : 64'(last_d));
            check("rnd.stall_cnt", 64'(stall_cnt), 64'(m_stall));

            drive(($urandom_range(0, 3) != 0), CW'($urandom), DW'($urandom),
                  ($urandom_range(0, 1) != 0), ($urandom_range(0, 31) == 0));

            if (mv && !out_ready && m_stall < STALL_MAX) m_stall++;
            if (flush) begin
                sb.delete();
            end else begin
                if (mv && out_ready) void'(sb.pop_front());
                if (in_valid && mr) sb.push_back('{c: in_ctrl, d: in_data});
            end
            if (sb.size() > 0) last_d = sb[0].d;
            next();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
